// File: rtl/zeroriscy_ppu_ctrl.sv
// Sequencing controller for the EX-stage posit unit: launches one operation,
// waits its fixed latency, captures the result and raises ready for retire.
module zeroriscy_ppu_ctrl #(
    parameter int WIDTH        = 32,
    parameter int PPU_OP_WIDTH = 3,
    parameter int LAT_ADDSUB   = 2,
    parameter int LAT_MUL      = 3,
    parameter int LAT_DIV      = 8,
    parameter int LAT_FMA      = 4,
    parameter int LAT_CONV     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ppu_en_i,
    input  logic [PPU_OP_WIDTH-1:0] ppu_operator_i,
    input  logic                    flush_i,
    output logic                    ppu_start_o,
    output logic [PPU_OP_WIDTH-1:0] ppu_op_o,
    output logic                    ppu_acc_clr_o,
    output logic                    ppu_abort_o,
    input  logic [WIDTH-1:0]        ppu_result_i,
    output logic [WIDTH-1:0]        ppu_result_o,
    output logic                    ppu_ready_o,
    output logic                    ppu_busy_o,
    output logic                    acc_valid_o,
    output logic [1:0]              dbg_state
);

    // Handshake: ppu_en_i is held high until ppu_ready_o; a cycle with both high
    // (IDLE with en low aside) is the retire cycle of the held instruction.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    localparam logic [PPU_OP_WIDTH-1:0] OP_FMADD_S = PPU_OP_WIDTH'(4);
    localparam logic [PPU_OP_WIDTH-1:0] OP_FMADD_C = PPU_OP_WIDTH'(5);

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [PPU_OP_WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    acc_q, acc_d;

    // Counter preload is L-1 so that cnt reaches zero on the L-th cycle after start.
    function automatic logic [4:0] lat_load(input logic [PPU_OP_WIDTH-1:0] op);
        case (op)
            PPU_OP_WIDTH'(0), PPU_OP_WIDTH'(1): lat_load = 5'(LAT_ADDSUB - 1);
            PPU_OP_WIDTH'(2):                   lat_load = 5'(LAT_MUL - 1);
            PPU_OP_WIDTH'(3):                   lat_load = 5'(LAT_DIV - 1);
            OP_FMADD_S, OP_FMADD_C:             lat_load = 5'(LAT_FMA - 1);
            default:                            lat_load = 5'(LAT_CONV - 1);
        endcase
    endfunction

    function automatic logic is_fma(input logic [PPU_OP_WIDTH-1:0] op);
        is_fma = (op == OP_FMADD_S) || (op == OP_FMADD_C);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        result_d      = result_q;
        acc_d         = acc_q;
        ppu_start_o   = 1'b0;
        ppu_op_o      = op_q;
        ppu_acc_clr_o = 1'b0;
        ppu_abort_o   = 1'b0;
        ppu_ready_o   = 1'b0;
        ppu_busy_o    = 1'b0;
        case (state_q)
            IDLE: begin
                ppu_ready_o = !ppu_en_i;
                if (ppu_en_i && !flush_i) begin
                    ppu_start_o   = 1'b1;
                    ppu_op_o      = ppu_operator_i;
                    // A continue with no open sum must behave like a fresh start.
                    ppu_acc_clr_o = (ppu_operator_i == OP_FMADD_S) ||
                                    ((ppu_operator_i == OP_FMADD_C) && !acc_q);
                    op_d          = ppu_operator_i;
                    cnt_d         = lat_load(ppu_operator_i);
                    state_d       = RUN;
                end
            end
            RUN: begin
                ppu_busy_o = 1'b1;
                if (flush_i) begin
                    ppu_abort_o = 1'b1;
                    state_d     = IDLE;
                    if (is_fma(op_q)) acc_d = 1'b0;
                end else if (cnt_q == 5'd0) begin
                    result_d = ppu_result_i;
                    state_d  = DONE;
                    if (is_fma(op_q)) acc_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                ppu_ready_o = 1'b1;
                ppu_abort_o = flush_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ppu_result_o = result_q;
    assign acc_valid_o  = acc_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_zeroriscy_ppu_ctrl.sv
// Bench for zeroriscy_ppu_ctrl: directed scenarios plus random instruction
// streams checked against a transaction-level timing/accumulator model.
module tb_zeroriscy_ppu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  op_in;
    logic        flush;
    logic        start_o;
    logic [2:0]  op_o;
    logic        clr_o;
    logic        abort_o;
    logic [31:0] res_in;
    logic [31:0] res_o;
    logic        ready_o;
    logic        busy_o;
    logic        acc_o;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_result = '0;
    logic        m_acc    = 1'b0;

    zeroriscy_ppu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ppu_en_i(en), .ppu_operator_i(op_in),
        .flush_i(flush), .ppu_start_o(start_o), .ppu_op_o(op_o),
        .ppu_acc_clr_o(clr_o), .ppu_abort_o(abort_o), .ppu_result_i(res_in),
        .ppu_result_o(res_o), .ppu_ready_o(ready_o), .ppu_busy_o(busy_o),
        .acc_valid_o(acc_o), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int lat(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: lat = 2;
            3'd2:       lat = 3;
            3'd3:       lat = 8;
            3'd4, 3'd5: lat = 4;
            default:    lat = 2;
        endcase
    endfunction

    // One instruction from its IDLE start cycle (t=0) to retire (t=L+1) or flush.
    // flush_at = -1 means no flush; 1..L+1 flushes in that cycle.
    task automatic run_instr(input string name, input logic [2:0] op, input int flush_at,
                             input bit use_fixed, input logic [31:0] fixed_res);
        int L = lat(op);
        logic exp_clr = (op == 3'd4) || (op == 3'd5 && !m_acc);
        logic [8:0] exp_v, got_v;
        for (int t = 0; t <= L + 1; t++) begin
            en     = 1'b1;
            op_in  = op;
            flush  = (t == flush_at);
            res_in = (use_fixed && t == L) ? fixed_res : $urandom;
            @(negedge clk);
            exp_v = {t == 0, t == L + 1, (t >= 1 && t <= L), t == flush_at,
                     (t == 0) && exp_clr, op, 1'b0};
            got_v = {start_o, ready_o, busy_o, abort_o, clr_o, op_o, 1'b0};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s ctrl t=%0d got %b exp %b (start,ready,busy,abort,clr,op)",
                         name, t, got_v, exp_v);
            end
            n_tests++;
            if (res_o !== m_result || acc_o !== m_acc) begin
                n_fail++;
                $display("FAIL %s regs t=%0d got res=%h acc=%b exp res=%h acc=%b",
                         name, t, res_o, acc_o, m_result, m_acc);
            end
            if (t == L && flush_at != L) begin
                m_result = res_in;
                if (op == 3'd4 || op == 3'd5) m_acc = 1'b1;
            end
            if (t == flush_at && t >= 1 && t <= L && (op == 3'd4 || op == 3'd5)) m_acc = 1'b0;
            @(posedge clk);
            #1;
            if (t == flush_at) break;
        end
        flush = 1'b0;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            en     = 1'b0;
            flush  = 1'b0;
            res_in = $urandom;
            @(negedge clk);
            n_tests++;
            if ({start_o, ready_o, busy_o, abort_o, clr_o} !== 5'b01000 ||
                res_o !== m_result || acc_o !== m_acc) begin
                n_fail++;
                $display("FAIL %s idle got s/r/b/a/c=%b res=%h acc=%b exp 01000 res=%h acc=%b",
                         name, {start_o, ready_o, busy_o, abort_o, clr_o}, res_o, acc_o,
                         m_result, m_acc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if ({start_o, ready_o, busy_o, abort_o, clr_o} !== 5'b01000 || op_o !== 3'd0 ||
            res_o !== 32'd0 || acc_o !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL %s got s/r/b/a/c=%b op=%0d res=%h acc=%b st=%0d exp 01000 op=0 res=0 acc=0 st=0",
                     name, {start_o, ready_o, busy_o, abort_o, clr_o}, op_o, res_o, acc_o, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; op_in = 3'd0; res_in = '0;
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles("reset_idle", 2);
    endtask

    task automatic test_add();
        run_instr("add", 3'd0, -1, 1'b1, 32'h4000_0000);
        n_tests++;
        if (m_result !== 32'h4000_0000 || res_o !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL add_result got %h exp 40000000", res_o);
        end
        idle_cycles("add_idle", 1);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_div", 3'd3, -1, 1'b0, '0);
        run_instr("b2b_mul", 3'd2, -1, 1'b0, '0);
        idle_cycles("b2b_idle", 1);
    endtask

    task automatic test_fma();
        run_instr("fma_c_first", 3'd5, -1, 1'b0, '0);
        run_instr("fma_c_second", 3'd5, -1, 1'b0, '0);
        idle_cycles("fma_idle", 1);
        run_instr("fma_s_flush", 3'd4, 2, 1'b0, '0);
        idle_cycles("fma_flush_idle", 1);
    endtask

    task automatic test_flush_at_zero();
        run_instr("div_flush_cnt0", 3'd3, 8, 1'b0, '0);
        idle_cycles("div_flush_idle", 1);
    endtask

    task automatic test_flush_idle();
        en = 1'b1; op_in = 3'($urandom_range(0, 7)); flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({start_o, ready_o, busy_o, abort_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_idle got s/r/b/a=%b exp 0000", {start_o, ready_o, busy_o, abort_o});
        end
        @(posedge clk);
        #1;
        idle_cycles("flush_idle_after", 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            int fl = -1;
            if ($urandom_range(0, 3) == 0) fl = $urandom_range(1, lat(op));
            run_instr("random", op, fl, 1'b0, '0);
            idle_cycles("random_gap", $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_op();
        en = 1'b1; op_in = 3'd3; flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy got %b exp 1", busy_o);
        end
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_reset_values("reset_mid_op");
        m_result = '0;
        m_acc    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles("reset_mid_idle", 2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_fma();
        test_flush_at_zero();
        test_flush_idle();
        test_random();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroriscy_ppu_ctrl.md
Name: zeroriscy_ppu_ctrl

Overview:
Sequencing controller for the single posit processing unit (PPU) in the EX stage. It accepts PPU instructions from the ID/EX control path and launches each one on the PPU datapath. It counts the per-operation fixed latency, captures the result and returns EX-ready so the instruction can retire. It also tracks the fused-MAC accumulator state across FMADD_S/FMADD_C sequences and handles pipeline flush mid-operation.

Parameters:
WIDTH, 32, PPU operand/result width in bits
PPU_OP_WIDTH, 3, operator field width
LAT_ADDSUB, 2, cycles from start to PPU result for PPU_ADD/PPU_SUB (range 1..31)
LAT_MUL, 3, latency for PPU_MUL (range 1..31)
LAT_DIV, 8, latency for PPU_DIV (range 1..31)
LAT_FMA, 4, latency for FMADD_S/FMADD_C (range 1..31)
LAT_CONV, 2, latency for FLOAT_TO_POSIT/POSIT_TO_FLOAT (range 1..31)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ppu_en_i  in  1  PPU instruction present in EX; held high until ppu_ready_o
ppu_operator_i  in  3  opcode: ADD=0 SUB=1 MUL=2 DIV=3 FMADD_S=4 FMADD_C=5 F2P=6 P2F=7
flush_i  in  1  kill the in-flight EX instruction
ppu_start_o  out  1  one-cycle launch strobe to the PPU datapath
ppu_op_o  out  3  operator presented with ppu_start_o
ppu_acc_clr_o  out  1  with ppu_start_o: clear accumulator before the MAC
ppu_abort_o  out  1  one-cycle abort strobe to the datapath
ppu_result_i  in  WIDTH  PPU datapath result
ppu_result_o  out  WIDTH  registered result to the writeback mux
ppu_ready_o  out  1  EX ready / retire for the PPU instruction
ppu_busy_o  out  1  operation in flight (perf counter, debug)
acc_valid_o  out  1  accumulator holds a valid partial sum

Behaviour:
- Reset (async, rst_n=0): state IDLE, cnt=0, ppu_result_o=0, acc_valid_o=0, op register=0. All strobes are 0, ppu_busy_o=0, ppu_ready_o=1.
- Latency lookup L(op): ADD/SUB→LAT_ADDSUB, MUL→LAT_MUL, DIV→LAT_DIV, FMADD_S/C→LAT_FMA, F2P/P2F→LAT_CONV. Counter width is 5 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ppu_ready_o = !ppu_en_i.
  - If ppu_en_i && !flush_i: combinationally assert ppu_start_o and ppu_op_o=ppu_operator_i in this cycle (cycle 0). Latch op, load cnt=L(op)-1, go to RUN.
- RUN:
  - ppu_busy_o=1, ppu_ready_o=0.
  - cnt decrements each cycle.
  - When cnt==0 (cycle L): register ppu_result_i into ppu_result_o and go to DONE.
- DONE:
  - ppu_ready_o=1 for exactly one cycle (cycle L+1), which is the retire cycle.
  - Always return to IDLE; ppu_en_i in DONE belongs to the retiring instruction and is ignored.
  - Total en-to-ready = L+1 cycles; back-to-back instructions start one cycle apart from the previous DONE.
- ppu_op_o is held at the latched op outside the start cycle. ppu_start_o is never asserted outside IDLE.
- Accumulator rules:
  - FMADD_S: ppu_acc_clr_o=1 with start.
  - FMADD_C: ppu_acc_clr_o = !acc_valid_o, i.e. a continue with no open sum behaves as a start. ppu_op_o still equals FMADD_C.
  - acc_valid_o is set on the RUN→DONE transition of FMADD_S or FMADD_C.
  - Other ops leave acc_valid_o unchanged.
- Flush:
  - flush_i in RUN or DONE: go to IDLE next cycle, ppu_abort_o=1 in the flush cycle, ppu_result_o unchanged.
  - If the flushed op is FMADD_S/C and still in RUN, clear acc_valid_o.
  - flush_i in DONE does not alter acc_valid_o if already set.
  - flush_i in IDLE suppresses a start; ppu_abort_o=0.
- Simultaneous flush_i and cnt==0: flush wins; no capture, no ready.
- Reset mid-operation aborts silently. No ppu_abort_o is generated; the datapath shares the same reset.

Test Plan:
- Reset, then ADD (op=0) held high, ppu_result_i=32'h4000_0000 at cycle 2 -> start_o pulse at cycle 0, ready_o=1 only at cycle 3, result_o=32'h4000_0000, busy_o high cycles 1-2.
- DIV (op=3) followed immediately by MUL (op=2) -> DIV ready at cycle 9, MUL start at cycle 10, MUL ready at cycle 14; exactly two start pulses total.
- FMADD_C (op=5) after reset -> acc_clr_o=1 with start, acc_valid_o=1 after DONE. A second FMADD_C -> acc_clr_o=0.
- FMADD_S, flush_i at cycle 2 of RUN -> abort_o pulse at cycle 2, IDLE at cycle 3, no ready pulse, acc_valid_o=0, result_o unchanged.
- DIV with flush_i asserted in the same cycle cnt reaches 0 -> no capture, ready_o stays low until IDLE, abort_o=1.
- rst_n low at cycle 4 of DIV -> all outputs return to reset values asynchronously; after release, idle ready_o=1 with en low.
